// File: rtl/ro_cache_refill.sv
// Read-only cache line refill engine: fetches one line over an external burst
// port and streams the beats, in order, through a 2-entry FIFO into the data memory.
module ro_cache_refill #(
   parameter int unsigned mem_depth  = 32,
   parameter int unsigned data_width = 32,
   parameter int unsigned line_words = 4,
   parameter int unsigned addr_width = 32
) (
   input  logic                                    clk,
   input  logic                                    rst,
   input  logic                                    miss_req,
   input  logic [addr_width-1:0]                   miss_addr,
   output logic                                    miss_ready,
   output logic                                    busy,
   output logic                                    refill_done,
   output logic [$clog2(mem_depth/line_words)-1:0] refill_line_idx,
   output logic                                    ext_req,
   output logic [addr_width-1:0]                   ext_addr,
   input  logic                                    ext_ack,
   input  logic                                    ext_rvalid,
   input  logic [data_width-1:0]                   ext_rdata,
   output logic                                    ext_rready,
   output logic [$clog2(mem_depth)-1:0]            fetch_mem_waddr,
   output logic                                    fetch_mem_wen,
   input  logic                                    fetch_mem_wready,
   output logic [data_width-1:0]                   fetch_mem_wdata
);

   localparam int unsigned LW_W = $clog2(line_words);
   localparam int unsigned LI_W = $clog2(mem_depth/line_words);
   localparam int unsigned MA_W = $clog2(mem_depth);
   localparam int unsigned RC_W = LW_W + 1;

   typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

   state_t                state_q, state_d;
   logic [LI_W-1:0]       line_idx_q, line_idx_d;
   logic [addr_width-1:0] base_q, base_d;
   logic [RC_W-1:0]       rcv_cnt_q, rcv_cnt_d;
   logic [LW_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [data_width-1:0] fifo_q [2];
   logic [data_width-1:0] fifo_d [2];
   logic                  wptr_q, wptr_d;
   logic                  rptr_q, rptr_d;
   logic [1:0]            fcnt_q, fcnt_d;

   logic                  miss_ready_q, miss_ready_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic                  ext_req_q, ext_req_d;
   logic [addr_width-1:0] ext_addr_q, ext_addr_d;
   logic                  rready_q, rready_d;
   logic                  wen_q, wen_d;
   logic [MA_W-1:0]       waddr_q, waddr_d;
   logic [data_width-1:0] wdata_q, wdata_d;

   logic                  push;
   logic                  pop;

   // Next-state logic; outputs are registered from the next-state values.
   always_comb begin
      state_d    = state_q;
      line_idx_d = line_idx_q;
      base_d     = base_q;
      rcv_cnt_d  = rcv_cnt_q;
      wr_cnt_d   = wr_cnt_q;
      fifo_d     = fifo_q;
      wptr_d     = wptr_q;
      rptr_d     = rptr_q;
      fcnt_d     = fcnt_q;
      push       = (state_q == DATA) && ext_rvalid && rready_q;
      pop        = (state_q == DATA) && wen_q && fetch_mem_wready;

      unique case (state_q)
         IDLE: begin
            if (miss_req && miss_ready_q) begin
               line_idx_d = miss_addr[LW_W +: LI_W];
               base_d     = {miss_addr[addr_width-1:LW_W], LW_W'(0)};
               rcv_cnt_d  = '0;
               wr_cnt_d   = '0;
               wptr_d     = 1'b0;
               rptr_d     = 1'b0;
               fcnt_d     = '0;
               state_d    = ADDR;
            end
         end
         ADDR: begin
            if (ext_ack) begin
               state_d = DATA;
            end
         end
         DATA: begin
            if (push) begin
               fifo_d[wptr_q] = ext_rdata;
               wptr_d         = ~wptr_q;
               rcv_cnt_d      = rcv_cnt_q + RC_W'(1);
            end
            if (pop) begin
               rptr_d = ~rptr_q;
               if (wr_cnt_q == LW_W'(line_words - 1)) begin
                  wr_cnt_d = '0;
                  state_d  = DONE;
               end else begin
                  wr_cnt_d = wr_cnt_q + LW_W'(1);
               end
            end
            fcnt_d = fcnt_q + 2'(push) - 2'(pop);
         end
         DONE: begin
            state_d = IDLE;
         end
      endcase

      miss_ready_d = (state_d == IDLE);
      busy_d       = (state_d != IDLE);
      done_d       = (state_d == DONE);
      ext_req_d    = (state_d == ADDR);
      ext_addr_d   = base_d;
      rready_d     = (state_d == DATA) && (fcnt_d != 2'd2) && (rcv_cnt_d < RC_W'(line_words));
      wen_d        = (state_d == DATA) && (fcnt_d != 2'd0);
      waddr_d      = {line_idx_d, wr_cnt_d};
      wdata_d      = fifo_d[rptr_d];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         line_idx_q   <= '0;
         base_q       <= '0;
         rcv_cnt_q    <= '0;
         wr_cnt_q     <= '0;
         fifo_q[0]    <= '0;
         fifo_q[1]    <= '0;
         wptr_q       <= 1'b0;
         rptr_q       <= 1'b0;
         fcnt_q       <= '0;
         miss_ready_q <= 1'b1;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ext_req_q    <= 1'b0;
         ext_addr_q   <= '0;
         rready_q     <= 1'b0;
         wen_q        <= 1'b0;
         waddr_q      <= '0;
         wdata_q      <= '0;
      end else begin
         state_q      <= state_d;
         line_idx_q   <= line_idx_d;
         base_q       <= base_d;
         rcv_cnt_q    <= rcv_cnt_d;
         wr_cnt_q     <= wr_cnt_d;
         fifo_q       <= fifo_d;
         wptr_q       <= wptr_d;
         rptr_q       <= rptr_d;
         fcnt_q       <= fcnt_d;
         miss_ready_q <= miss_ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ext_req_q    <= ext_req_d;
         ext_addr_q   <= ext_addr_d;
         rready_q     <= rready_d;
         wen_q        <= wen_d;
         waddr_q      <= waddr_d;
         wdata_q      <= wdata_d;
      end
   end

   assign miss_ready      = miss_ready_q;
   assign busy            = busy_q;
   assign refill_done     = done_q;
   assign refill_line_idx = line_idx_q;
   assign ext_req         = ext_req_q;
   assign ext_addr        = ext_addr_q;
   assign ext_rready      = rready_q;
   assign fetch_mem_wen   = wen_q;
   assign fetch_mem_waddr = waddr_q;
   assign fetch_mem_wdata = wdata_q;

endmodule

// File: tb/tb_ro_cache_refill.sv
// Bench for ro_cache_refill: directed and randomized refills checked against a
// line-level model (beat list, occupancy = beats accepted minus beats written).
module tb_ro_cache_refill;

   localparam int unsigned MEM_DEPTH = 32;
   localparam int unsigned DW        = 32;
   localparam int unsigned LW        = 4;
   localparam int unsigned AW        = 32;
   localparam int unsigned LI_W      = $clog2(MEM_DEPTH/LW);
   localparam int unsigned MA_W      = $clog2(MEM_DEPTH);

   logic            clk = 1'b0;
   logic            rst;
   logic            miss_req;
   logic [AW-1:0]   miss_addr;
   logic            miss_ready;
   logic            busy;
   logic            refill_done;
   logic [LI_W-1:0] refill_line_idx;
   logic            ext_req;
   logic [AW-1:0]   ext_addr;
   logic            ext_ack;
   logic            ext_rvalid;
   logic [DW-1:0]   ext_rdata;
   logic            ext_rready;
   logic [MA_W-1:0] fetch_mem_waddr;
   logic            fetch_mem_wen;
   logic            fetch_mem_wready;
   logic [DW-1:0]   fetch_mem_wdata;

   int checks = 0;
   int errors = 0;
   int last_idx = 0;

   ro_cache_refill #(
      .mem_depth(MEM_DEPTH), .data_width(DW), .line_words(LW), .addr_width(AW)
   ) dut (
      .clk(clk), .rst(rst),
      .miss_req(miss_req), .miss_addr(miss_addr), .miss_ready(miss_ready),
      .busy(busy), .refill_done(refill_done), .refill_line_idx(refill_line_idx),
      .ext_req(ext_req), .ext_addr(ext_addr), .ext_ack(ext_ack),
      .ext_rvalid(ext_rvalid), .ext_rdata(ext_rdata), .ext_rready(ext_rready),
      .fetch_mem_waddr(fetch_mem_waddr), .fetch_mem_wen(fetch_mem_wen),
      .fetch_mem_wready(fetch_mem_wready), .fetch_mem_wdata(fetch_mem_wdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_check();
      chk("idle_busy",       64'(busy),            64'(0));
      chk("idle_miss_ready", 64'(miss_ready),      64'(1));
      chk("idle_done",       64'(refill_done),     64'(0));
      chk("idle_ext_req",    64'(ext_req),         64'(0));
      chk("idle_rready",     64'(ext_rready),      64'(0));
      chk("idle_wen",        64'(fetch_mem_wen),   64'(0));
      chk("idle_line_idx",   64'(refill_line_idx), 64'(last_idx));
   endtask

   // One line refill driven and checked cycle by cycle at the falling edge.
   task automatic refill(input logic [AW-1:0] addr, input int ack_dly, input bit stray,
                         input int stall, input bit rnd, input bit hold,
                         input int abort_after, input bit chk_lat);
      logic [DW-1:0] beats [LW];
      logic [AW-1:0] base;
      int idx, t, bi, wi, occ, d;
      bit saw_full, aborted;
      for (int i = 0; i < int'(LW); i++) beats[i] = $urandom;
      base = addr & ~32'(LW - 1);
      idx  = int'((addr / LW) % (MEM_DEPTH / LW));

      idle_check();
      miss_req  = 1'b1;
      miss_addr = addr;
      @(negedge clk);
      t = 1;
      if (!hold) miss_req = 1'b0;

      for (int k = 0; k <= ack_dly; k++) begin
         if (hold) miss_addr = $urandom;
         chk("addr_ext_req",    64'(ext_req),         64'(1));
         chk("addr_ext_addr",   64'(ext_addr),        64'(base));
         chk("addr_rready",     64'(ext_rready),      64'(0));
         chk("addr_wen",        64'(fetch_mem_wen),   64'(0));
         chk("addr_miss_ready", 64'(miss_ready),      64'(0));
         chk("addr_line_idx",   64'(refill_line_idx), 64'(idx));
         ext_rvalid = stray && (k == 0);
         ext_rdata  = ~beats[0];
         ext_ack    = (k == ack_dly);
         @(negedge clk);
         t++;
         ext_rvalid = 1'b0;
         ext_ack    = 1'b0;
      end

      bi = 0; wi = 0; d = 0; saw_full = 0; aborted = 0;
      while (wi < int'(LW)) begin
         if (d > 200) begin
            chk("data_timeout", 64'(wi), 64'(LW));
            break;
         end
         occ = bi - wi;
         if (hold) miss_addr = $urandom;
         chk("data_busy",       64'(busy),            64'(1));
         chk("data_done",       64'(refill_done),     64'(0));
         chk("data_miss_ready", 64'(miss_ready),      64'(0));
         chk("data_wen",        64'(fetch_mem_wen),   64'(occ > 0));
         chk("data_rready",     64'(ext_rready),      64'((occ < 2) && (bi < int'(LW))));
         chk("data_line_idx",   64'(refill_line_idx), 64'(idx));
         if (occ == 2 && ext_rready === 1'b0) saw_full = 1;
         ext_rvalid       = (bi < int'(LW)) && (!rnd || $urandom_range(0, 3) != 0);
         ext_rdata        = ext_rvalid ? beats[bi] : DW'($urandom);
         fetch_mem_wready = (d >= stall) && (!rnd || $urandom_range(0, 3) != 0);
         ext_ack          = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
         if (fetch_mem_wen && fetch_mem_wready) begin
            chk("wr_addr", 64'(fetch_mem_waddr), 64'(idx * int'(LW) + wi));
            chk("wr_data", 64'(fetch_mem_wdata), 64'(beats[wi]));
            wi++;
         end
         if (ext_rvalid && ext_rready) bi++;
         @(negedge clk);
         t++; d++;
         ext_ack = 1'b0;
         if (abort_after >= 0 && wi == abort_after) begin
            aborted = 1;
            break;
         end
      end
      if (stall > 0) chk("fifo_full_seen", 64'(saw_full), 64'(1));

      if (aborted) begin
         rst = 1'b1;
         ext_rvalid = 1'b1;
         ext_rdata = beats[bi < int'(LW) ? bi : 0];
         fetch_mem_wready = 1'b1;
         @(negedge clk);
         rst = 1'b0;
         ext_rvalid = 1'b0;
         last_idx = 0;
         chk("rst_wen",        64'(fetch_mem_wen),   64'(0));
         chk("rst_busy",       64'(busy),            64'(0));
         chk("rst_done",       64'(refill_done),     64'(0));
         chk("rst_rready",     64'(ext_rready),      64'(0));
         chk("rst_waddr",      64'(fetch_mem_waddr), 64'(0));
         chk("rst_line_idx",   64'(refill_line_idx), 64'(0));
         for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("post_rst_done", 64'(refill_done), 64'(0));
            chk("post_rst_wen",  64'(fetch_mem_wen), 64'(0));
         end
      end else begin
         ext_rvalid = 1'b0;
         fetch_mem_wready = 1'b1;
         if (hold) miss_addr = $urandom;
         chk("done_pulse",      64'(refill_done),     64'(1));
         chk("done_busy",       64'(busy),            64'(1));
         chk("done_miss_ready", 64'(miss_ready),      64'(0));
         chk("done_wen",        64'(fetch_mem_wen),   64'(0));
         chk("done_line_idx",   64'(refill_line_idx), 64'(idx));
         if (chk_lat) chk("done_latency", 64'(t), 64'(2 + LW + 1));
         @(negedge clk);
         last_idx = idx;
      end
   endtask

   initial begin
      rst = 1'b1; miss_req = 1'b0; miss_addr = '0; ext_ack = 1'b0;
      ext_rvalid = 1'b0; ext_rdata = '0; fetch_mem_wready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("reset_miss_ready", 64'(miss_ready),      64'(1));
      chk("reset_busy",       64'(busy),            64'(0));
      chk("reset_done",       64'(refill_done),     64'(0));
      chk("reset_ext_req",    64'(ext_req),         64'(0));
      chk("reset_rready",     64'(ext_rready),      64'(0));
      chk("reset_wen",        64'(fetch_mem_wen),   64'(0));
      chk("reset_ext_addr",   64'(ext_addr),        64'(0));
      chk("reset_waddr",      64'(fetch_mem_waddr), 64'(0));
      chk("reset_line_idx",   64'(refill_line_idx), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      // Minimum-latency refill of line 4 (words 16..19).
      refill(32'h0000_0013, 0, 0, 0, 0, 0, -1, 1);
      // Write side stalled for 5 cycles from the first beat.
      refill($urandom, 0, 0, 5, 0, 0, -1, 0);
      // Delayed ack with a stray beat while the address is outstanding.
      refill($urandom, 3, 1, 0, 0, 0, -1, 0);
      // miss_req held through a refill; the next request lands right after DONE.
      refill($urandom, 1, 0, 0, 0, 1, -1, 0);
      refill($urandom, 0, 0, 0, 0, 0, -1, 1);
      // Reset after two beats have been written, then a clean refill.
      refill($urandom, 0, 0, 0, 0, 0, 2, 0);
      refill($urandom, 0, 0, 0, 0, 0, -1, 1);
      // Randomized handshakes.
      for (int n = 0; n < 20; n++) begin
         refill($urandom, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                0, 1, 1'($urandom_range(0, 1)), -1, 0);
      end
      miss_req = 1'b0;
      idle_check();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ro_cache_refill.md
RO_CACHE_REFILL -- requirements
Module: ro_cache_refill

Interface
REQ-001 Parameter mem_depth, default 32: data-memory depth in words; power of two.
REQ-002 Parameter data_width, default 32: word width in bits.
REQ-003 Parameter line_words, default 4: words per cache line; power of two, at least 2, at most mem_depth.
REQ-004 Parameter addr_width, default 32: external word-address width.
REQ-005 The design SHALL have one clock; reset is synchronous and active-high. Ports are clk (input, 1, clock) and rst (input, 1, synchronous active-high reset).
REQ-006 miss_req  input  1  refill request valid.
REQ-007 miss_addr  input  addr_width  word address of the missing word.
REQ-008 miss_ready  output  1  request accepted when miss_req and miss_ready are both high.
REQ-009 busy  output  1  refill in progress.
REQ-010 refill_done  output  1  one-cycle pulse when the line is completely written.
REQ-011 refill_line_idx  output  $clog2(mem_depth/line_words)  line slot of the current or last refill.
REQ-012 ext_req  output  1  external burst read request.
REQ-013 ext_addr  output  addr_width  line-aligned external word address.
REQ-014 ext_ack  input  1  burst request accepted.
REQ-015 ext_rvalid  input  1  external data beat valid.
REQ-016 ext_rdata  input  data_width  external data beat.
REQ-017 ext_rready  output  1  beat accepted when ext_rvalid and ext_rready are both high.
REQ-018 fetch_mem_waddr  output  $clog2(mem_depth)  data-memory write address.
REQ-019 fetch_mem_wen  output  1  data-memory write request.
REQ-020 fetch_mem_wready  input  1  write accepted when fetch_mem_wen and fetch_mem_wready are both high.
REQ-021 fetch_mem_wdata  output  data_width  data-memory write data.

Function
REQ-022 The FSM SHALL have states IDLE, ADDR, DATA and DONE.
REQ-023 IDLE behaviour: miss_ready=1, busy=0. On a miss_req handshake:
- capture line_idx = miss_addr[$clog2(line_words) +: $clog2(mem_depth/line_words)];
- capture line base = miss_addr with the low $clog2(line_words) bits zeroed;
- go to ADDR.
REQ-024 ADDR behaviour: ext_req=1, ext_addr=line base, held stable until ext_ack. ext_ack moves the FSM to DATA the next cycle.
REQ-025 DATA behaviour: accept beats into a 2-entry FIFO.
- ext_rready = (FIFO not full) AND (received count < line_words).
- The received count increments on each accepted beat.
REQ-026 FIFO head drive: fetch_mem_wen = FIFO not empty; fetch_mem_wdata = head entry; fetch_mem_waddr = {line_idx, write count}. The write count increments on each write handshake.
REQ-027 Push and pop in the same cycle SHALL both occur, including when the FIFO is full. Occupancy is unchanged in that case.
REQ-028 Beats SHALL be written in arrival order, beat 0 first, with no reordering and no dropped beats.
REQ-029 When the write count reaches line_words, the FSM SHALL enter DONE. The count wraps to 0.
REQ-030 DONE lasts one cycle: refill_done=1, then return to IDLE. miss_ready SHALL be 0 in DONE, so the earliest next request is accepted in the cycle after DONE.
REQ-031 busy=1 in ADDR, DATA and DONE.
REQ-032 ext_rvalid SHALL be ignored outside DATA, and ext_rready=0 outside DATA.
REQ-033 ext_ack SHALL be ignored outside ADDR.
REQ-034 fetch_mem_wen=0 outside DATA.
REQ-035 A miss_req arriving while busy SHALL NOT be accepted, and SHALL NOT alter the captured line_idx or address.
REQ-036 Minimum latency, with ext_ack in the first ADDR cycle, beats back-to-back and fetch_mem_wready=1:
- miss handshake at cycle 0;
- refill_done at cycle 2+line_words+1.
REQ-037 refill_line_idx SHALL hold its value after DONE until the next accepted request.

Reset
REQ-038 Reset SHALL apply on the rising clk edge with rst=1.
REQ-039 Reset values:
- FSM=IDLE; FIFO empty; counts=0; line_idx=0; line base=0.
- Outputs: miss_ready=1, busy=0, refill_done=0, ext_req=0, ext_rready=0, fetch_mem_wen=0, ext_addr=0, fetch_mem_waddr=0, refill_line_idx=0.
REQ-040 Reset mid-refill SHALL abandon the line with no further writes and no refill_done pulse. A partially written line is left as is; the tag owner invalidates it.

Verification
REQ-041 Scenario: defaults, miss_addr=0x0000_0013, ext_ack immediate, beats A0..A3 back-to-back, wready=1. Required response:
- ext_addr=0x10;
- writes to addresses 16,17,18,19 with data A0..A3;
- refill_done 7 cycles after the request;
- refill_line_idx=4.
REQ-042 Scenario: fetch_mem_wready=0 for 5 cycles from the first beat. Required response:
- FIFO fills to 2 and ext_rready drops;
- after wready=1, all 4 beats are written in order with no loss.
REQ-043 Scenario: ext_ack delayed 3 cycles, with ext_rvalid pulsed in ADDR. Required response:
- ext_req and ext_addr stay stable;
- the stray beat is not consumed.
REQ-044 Scenario: miss_req held high through a refill with a changing miss_addr. Required response:
- only the first request is taken;
- the second is accepted in the cycle after DONE.
REQ-045 Scenario: rst=1 after 2 beats are written. Required response:
- next cycle fetch_mem_wen=0 and busy=0;
- no refill_done pulse;
- a new miss then refills correctly.
